// File: rtl/adder_bist_engine.sv
// Built-in self-test engine for combinational modN adders: drives corner and LFSR operand
// pairs, waits a settle window, checks the returned sum against a+b and tallies results.
module adder_bist_engine #(
  parameter int          WIDTH   = 32,
  parameter int          N_TESTS = 10000,
  parameter int          SETTLE  = 2,
  parameter logic [63:0] SEED    = 64'h0000_0000_0000_0005
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] dut_sum_i,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [31:0]      pass_count,
  output logic [31:0]      fail_count,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic [WIDTH-1:0] first_fail_sum
);

  localparam logic [63:0]      LFSR_MASK   = 64'hD800_0000_0000_0000;
  localparam logic [63:0]      SEED_EFF    = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [31:0]      LAST_IDX    = 32'(N_TESTS - 1);
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE - 1);
  localparam logic [31:0]      CNT_MAX     = 32'hFFFF_FFFF;
  localparam logic [WIDTH-1:0] ALL_ONES    = '1;
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_ONLY    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [63:0]      lfsr;
  logic [31:0]      index;
  logic [31:0]      settle_cnt;

  logic [63:0]      step1;
  logic [63:0]      step2;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic [WIDTH-1:0] golden;
  logic             sum_ok;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 64'd0);
  endfunction

  // Vector source: four corner cases first, then two LFSR steps per vector.
  always_comb begin
    step1 = lfsr_step(lfsr);
    step2 = lfsr_step(step1);
    vec_a = '0;
    vec_b = '0;
    case (index)
      32'd0: begin
        vec_a = '0;
        vec_b = '0;
      end
      32'd1: begin
        vec_a = ALL_ONES;
        vec_b = ONE;
      end
      32'd2: begin
        vec_a = ALL_ONES;
        vec_b = ALL_ONES;
      end
      32'd3: begin
        vec_a = MSB_ONLY;
        vec_b = MSB_ONLY;
      end
      default: begin
        vec_a = step1[WIDTH-1:0];
        vec_b = step2[WIDTH-1:0];
      end
    endcase
  end

  // Case equality so that an X/Z sum from the adder is treated as a mismatch.
  always_comb begin
    golden = a_o + b_o;
    sum_ok = (dut_sum_i === golden);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      lfsr           <= SEED_EFF;
      index          <= '0;
      settle_cnt     <= '0;
      a_o            <= '0;
      b_o            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_sum <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_GEN;
            lfsr           <= SEED_EFF;
            index          <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            all_pass       <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_sum <= '0;
          end
        end
        S_GEN: begin
          a_o        <= vec_a;
          b_o        <= vec_b;
          settle_cnt <= '0;
          if (index >= 32'd4) begin
            lfsr <= step2;
          end
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        S_CHECK: begin
          if (sum_ok) begin
            if (pass_count != CNT_MAX) begin
              pass_count <= pass_count + 32'd1;
            end
          end else begin
            if (fail_count != CNT_MAX) begin
              fail_count <= fail_count + 32'd1;
            end
            // Saturation never returns fail_count to zero, so only the first miss is captured.
            if (fail_count == 32'd0) begin
              first_fail_a   <= a_o;
              first_fail_b   <= b_o;
              first_fail_sum <= dut_sum_i;
            end
          end
          if (index == LAST_IDX) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            all_pass <= (fail_count == 32'd0) && sum_ok;
          end else begin
            index <= index + 32'd1;
            state <= S_GEN;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_engine.sv
// Directed bench for adder_bist_engine: three instances cover the 32-bit corner runs,
// a long reproducible 64-bit LFSR run, and an 8-bit instance with a zero seed.
module tb_adder_bist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start32, xor_mode;
  logic [31:0] a32, b32, sum32, ffa32, ffb32, ffs32, pc32, fc32;
  logic        busy32, done32, ap32;

  logic        start64;
  logic [63:0] a64, b64, sum64, ffa64, ffb64, ffs64;
  logic [31:0] pc64, fc64;
  logic        busy64, done64, ap64;

  logic        start8;
  logic [7:0]  a8, b8, sum8, ffa8, ffb8, ffs8;
  logic [31:0] pc8, fc8;
  logic        busy8, done8, ap8;

  // Adder models: xor_mode drops every carry to emulate a broken adder.
  assign sum32 = xor_mode ? (a32 ^ b32) : (a32 + b32);
  assign sum64 = a64 + b64;
  assign sum8  = a8 + b8;

  adder_bist_engine #(.WIDTH(32), .N_TESTS(4), .SETTLE(2)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a_o(a32), .b_o(b32), .dut_sum_i(sum32),
    .busy(busy32), .done(done32), .all_pass(ap32), .pass_count(pc32), .fail_count(fc32),
    .first_fail_a(ffa32), .first_fail_b(ffb32), .first_fail_sum(ffs32));

  adder_bist_engine #(.WIDTH(64), .N_TESTS(10000), .SETTLE(1), .SEED(64'h5)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .a_o(a64), .b_o(b64), .dut_sum_i(sum64),
    .busy(busy64), .done(done64), .all_pass(ap64), .pass_count(pc64), .fail_count(fc64),
    .first_fail_a(ffa64), .first_fail_b(ffb64), .first_fail_sum(ffs64));

  adder_bist_engine #(.WIDTH(8), .N_TESTS(6), .SETTLE(2), .SEED(64'h0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_o(a8), .b_o(b8), .dut_sum_i(sum8),
    .busy(busy8), .done(done8), .all_pass(ap8), .pass_count(pc8), .fail_count(fc8),
    .first_fail_a(ffa8), .first_fail_b(ffb8), .first_fail_sum(ffs8));

  int checks   = 0;
  int failures = 0;

  logic [63:0] expA [10000];
  logic [63:0] expB [10000];
  logic [63:0] runA [10000];
  logic [63:0] runB [10000];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lfsrStep(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'd0);
  endfunction

  // Starts the 32-bit engine and counts edges until done; optionally re-pulses start mid-run.
  task automatic applyStimulus(input int pulse_at, output int cycles);
    @(negedge clk);
    start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    cycles = 0;
    while (!done32 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      start32 = (cycles == pulse_at);
    end
    start32 = 1'b0;
  endtask

  // 64-bit run with SETTLE=1: vector k is loaded at edge 1+3k after the start edge.
  task automatic run64(input bit second, output int cycles, output int errs);
    int k;
    errs = 0;
    @(negedge clk);
    start64 = 1'b1;
    @(posedge clk);
    #1 start64 = 1'b0;
    cycles = 0;
    while (!done64 && cycles < 31000) begin
      @(posedge clk);
      #1;
      cycles++;
      if ((cycles - 1) % 3 == 0 && (cycles - 1) / 3 < 10000) begin
        k = (cycles - 1) / 3;
        if (!second) begin
          runA[k] = a64;
          runB[k] = b64;
          if (a64 !== expA[k] || b64 !== expB[k]) errs++;
        end else begin
          if (a64 !== runA[k] || b64 !== runB[k]) errs++;
        end
      end
    end
  endtask

  initial begin
    int cyc, errs;
    logic [63:0] s;
    logic [63:0] v4a, v4b, v5a, v5b;

    rst_n = 1'b0; start32 = 1'b0; start64 = 1'b0; start8 = 1'b0; xor_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_a_o", a32, 0);
    checkOutput("rst_pass", pc32, 0);
    checkOutput("rst_busy_done", {busy32, done32, ap32}, 0);
    rst_n = 1'b1;

    // Correct adder over the four corner vectors.
    applyStimulus(-1, cyc);
    checkOutput("s1_cycles", cyc, 16);
    checkOutput("s1_pass", pc32, 4);
    checkOutput("s1_fail", fc32, 0);
    checkOutput("s1_all_pass", ap32, 1);
    checkOutput("s1_first_fail", {ffa32, ffb32}, 0);
    checkOutput("s1_ff_sum", ffs32, 0);
    checkOutput("s1_last_vec", {a32, b32}, {32'h8000_0000, 32'h8000_0000});
    checkOutput("s1_busy", busy32, 0);

    // Carry-less adder, restarted from DONE.
    xor_mode = 1'b1;
    applyStimulus(-1, cyc);
    checkOutput("s2_cycles", cyc, 16);
    checkOutput("s2_pass", pc32, 2);
    checkOutput("s2_fail", fc32, 2);
    checkOutput("s2_all_pass", ap32, 0);
    checkOutput("s2_ff_a", ffa32, 32'hFFFF_FFFF);
    checkOutput("s2_ff_b", ffb32, 32'h1);
    checkOutput("s2_ff_sum", ffs32, 32'hFFFF_FFFE);
    xor_mode = 1'b0;

    // start pulsed while vector 2 is in WAIT must not restart the run.
    applyStimulus(9, cyc);
    checkOutput("s4_cycles", cyc, 16);
    checkOutput("s4_pass", pc32, 4);
    checkOutput("s4_fail", fc32, 0);
    checkOutput("s4_ff_cleared", ffs32, 0);

    // Reset asserted for the edge that would complete CHECK of vector 3.
    @(negedge clk);
    start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("s5_busy_before", busy32, 1);
    checkOutput("s5_pass_before", pc32, 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("s5_rst_ops", {a32, b32}, 0);
    checkOutput("s5_rst_cnt", {pc32, fc32}, 0);
    checkOutput("s5_rst_flags", {busy32, done32, ap32}, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s5_stays_idle", busy32, 0);
    applyStimulus(-1, cyc);
    checkOutput("s5_cycles", cyc, 16);
    checkOutput("s5_pass", pc32, 4);
    checkOutput("s5_all_pass", ap32, 1);

    // Zero seed: engine must load 1 and walk the Galois sequence from there.
    s = 64'h1;
    s = lfsrStep(s); v4a = s;
    s = lfsrStep(s); v4b = s;
    s = lfsrStep(s); v5a = s;
    s = lfsrStep(s); v5b = s;
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 17) checkOutput("s6_vec4", {a8, b8}, {v4a[7:0], v4b[7:0]});
    end
    checkOutput("s6_cycles", cyc, 24);
    checkOutput("s6_pass", pc8, 6);
    checkOutput("s6_vec5", {a8, b8}, {v5a[7:0], v5b[7:0]});

    // Long 64-bit run against an independent LFSR model, then a bit-exact rerun.
    s = 64'h5;
    for (int k = 0; k < 10000; k++) begin
      case (k)
        0: begin expA[k] = 64'd0;         expB[k] = 64'd0;         end
        1: begin expA[k] = '1;            expB[k] = 64'd1;         end
        2: begin expA[k] = '1;            expB[k] = '1;            end
        3: begin expA[k] = 64'h8000_0000_0000_0000; expB[k] = 64'h8000_0000_0000_0000; end
        default: begin
          s = lfsrStep(s); expA[k] = s;
          s = lfsrStep(s); expB[k] = s;
        end
      endcase
    end
    run64(1'b0, cyc, errs);
    checkOutput("s3_run1_cycles", cyc, 30000);
    checkOutput("s3_run1_vectors", errs, 0);
    checkOutput("s3_run1_pass", pc64, 10000);
    checkOutput("s3_run1_fail", fc64, 0);
    checkOutput("s3_run1_all_pass", ap64, 1);
    run64(1'b1, cyc, errs);
    checkOutput("s3_run2_cycles", cyc, 30000);
    checkOutput("s3_run2_repeat", errs, 0);
    checkOutput("s3_run2_pass", pc64, 10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_bist_engine.md
Name: adder_bist_engine

Overview:
- Sequential stimulus and checker stage that wraps any combinational modN adder in the family (prefix, Jackson, Ling node adders).
- Generates operand pairs: four fixed corner vectors, then a 64-bit Galois LFSR stream.
- Drives the operands into the adder under test, waits a settle window, then compares the returned sum against an internal a+b golden.
- Accumulates pass/fail counts and captures the first failing vector, so silicon and FPGA self-test match the bench's pass-rate report.

Parameters:
- WIDTH, 32, operand/sum width; legal range 8..64.
- N_TESTS, 10000, total vectors per run, corner vectors included; must be ≥1.
- SETTLE, 2, cycles operands are held before the sum is sampled; must be ≥1.
- SEED, 64'h0000_0000_0000_0005, LFSR reload value; 0 is replaced by 64'h1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- a_o  out  WIDTH  operand A to the adder under test; registered.
- b_o  out  WIDTH  operand B to the adder under test; registered.
- dut_sum_i  in  WIDTH  sum returned by the adder under test.
- busy  out  1  high in GEN, WAIT and CHECK.
- done  out  1  high in DONE.
- all_pass  out  1  done && fail_count==0.
- pass_count  out  32  matching vectors; saturates at 32'hFFFF_FFFF.
- fail_count  out  32  mismatching vectors; saturates at 32'hFFFF_FFFF.
- first_fail_a  out  WIDTH  A of the first mismatch.
- first_fail_b  out  WIDTH  B of the first mismatch.
- first_fail_sum  out  WIDTH  dut_sum_i captured at the first mismatch.

Behaviour:
- Reset (rst_n=0 at an edge, any state including mid-run):
  - state=IDLE, LFSR=SEED (or 1 if SEED==0), vector index=0, settle counter=0.
  - All outputs 0, including a_o, b_o, counters and first_fail_*.
  - The run is abandoned; there is no resume.
- Corner vectors, indices 0..3, applied before any LFSR vector:
  - index 0: (0, 0)
  - index 1: (all-ones, 1)
  - index 2: (all-ones, all-ones)
  - index 3: (MSB-only, MSB-only)
  - If N_TESTS<4, only the first N_TESTS corner vectors are applied.
- LFSR:
  - 64-bit Galois, right-shifting, feedback mask 64'hD800_0000_0000_0000.
  - Each LFSR vector steps the LFSR twice: a = state[WIDTH-1:0] after step 1, b = state[WIDTH-1:0] after step 2.
  - Both steps are computed combinationally within the GEN cycle.
  - The LFSR is not stepped during corner vectors.
- FSM states: IDLE, GEN, WAIT, CHECK, DONE.
  - IDLE: start=1 → GEN. Counters, first_fail_* and index are cleared on this transition; the LFSR is reloaded with SEED.
  - GEN, 1 cycle: a_o/b_o are loaded with vector[index] at the exiting edge; settle counter cleared → WAIT.
  - WAIT, exactly SETTLE cycles: a_o/b_o held stable → CHECK.
  - CHECK, 1 cycle: golden = (a_o + b_o) mod 2^WIDTH, carry-out discarded.
    - If dut_sum_i==golden, pass_count++; else fail_count++.
    - On the first mismatch of the run (fail_count was 0), capture a_o, b_o, dut_sum_i into first_fail_*.
    - If index==N_TESTS-1 → DONE; else index++ → GEN.
  - DONE: outputs held, a_o/b_o hold the last vector. start=1 → GEN with the same clearing and SEED reload as from IDLE. This makes runs reproducible.
- start while busy: ignored, no restart.
- Per-vector cost: SETTLE+2 cycles. done rises N_TESTS*(SETTLE+2) cycles after the edge that samples start.
- Invariant: at DONE, pass_count + fail_count == N_TESTS (for N_TESTS < 2^32).
- The index counter is 32 bits.
- The comparison is exact over WIDTH bits. X/Z on dut_sum_i counts as a mismatch; equality is evaluated with ===-safe semantics in the checker.

Test Plan:
1. WIDTH=32, N_TESTS=4, SETTLE=2, dut_sum_i = a_o+b_o → done high 16 cycles after start; pass_count=4, fail_count=0, all_pass=1, first_fail_* = 0.
2. Same parameters, dut_sum_i = a_o^b_o (no carries) →
   - index 0 (0+0) passes, index 1 fails, index 2 fails, index 3 (MSB+MSB=0) passes.
   - pass_count=2, fail_count=2, all_pass=0.
   - first_fail_a=32'hFFFF_FFFF, first_fail_b=32'h1, first_fail_sum=32'hFFFF_FFFE.
3. WIDTH=64, N_TESTS=10000, correct DUT → pass_count=10000. A second start from DONE reproduces identical a_o/b_o sequences, checked cycle by cycle against the first run.
4. Pulse start during WAIT of vector 2 → no restart; the total cycle count and counters equal those of an undisturbed run.
5. Drive rst_n=0 for one edge during CHECK of vector 3 → next cycle state=IDLE, all outputs 0. A fresh start yields the same results as scenario 1.
6. SEED=0, N_TESTS=6, WIDTH=8 → the LFSR is loaded with 1. Vectors 4/5 equal the low bytes of successive Galois steps from 1 (the bench computes the expected values); no lock-up at zero.
